// File: rtl/mix_cols_pipe.sv
// AES MixColumns / InvMixColumns engine, COLS_PER_CYCLE columns per clock.
// Optional MIX_COLS_BYPASS_EN adds bypass_in for the unmixed final round.
module mix_cols_pipe #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk_in,
    input  logic         rst_n_in,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         inv_in,
    input  logic [127:0] block_in,
    output logic [127:0] result_out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy_out
`ifdef MIX_COLS_BYPASS_EN
    ,
    input  logic         bypass_in
`endif
);

    localparam int NUM_STEPS = (COLS_PER_CYCLE > 0) ? 4 / COLS_PER_CYCLE : 1;
    localparam int SW = $clog2(NUM_STEPS) + 1;
    localparam logic [SW-1:0] LAST = SW'(NUM_STEPS - 1);

    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cpc
        $error("mix_cols_pipe: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {IDLE, MIX, DONE} state_t;

    state_t        state;
    logic [127:0]  blk;
    logic [127:0]  acc;
    logic [127:0]  acc_nxt;
    logic [SW-1:0] step;
    logic          inv_q;
    logic          byp_q;
    logic          byp_sample;
    logic [1:0]    col;
    logic [7:0]    a [4];

`ifdef MIX_COLS_BYPASS_EN
    assign byp_sample = bypass_in;
`else
    assign byp_sample = 1'b0;
`endif

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Coefficients are at most 0x0e, so a 3-deep xtime chain covers them.
    function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] k);
        logic [7:0] b2;
        logic [7:0] b4;
        logic [7:0] b8;
        b2 = xt(b);
        b4 = xt(b2);
        b8 = xt(b4);
        return ({8{k[0]}} & b) ^ ({8{k[1]}} & b2) ^
               ({8{k[2]}} & b4) ^ ({8{k[3]}} & b8);
    endfunction

    always_comb begin
        acc_nxt = acc;
        col = '0;
        a = '{default: '0};
        for (int j = 0; j < COLS_PER_CYCLE; j++) begin
            col = 2'(int'(step) * COLS_PER_CYCLE + j);
            for (int r = 0; r < 4; r++) begin
                a[r] = blk[8*(4*r+int'(col)) +: 8];
            end
            for (int r = 0; r < 4; r++) begin
                if (inv_q) begin
                    acc_nxt[8*(4*r+int'(col)) +: 8] =
                        gmul(a[r], 4'he) ^ gmul(a[(r+1)%4], 4'hb) ^
                        gmul(a[(r+2)%4], 4'hd) ^ gmul(a[(r+3)%4], 4'h9);
                end else begin
                    acc_nxt[8*(4*r+int'(col)) +: 8] =
                        gmul(a[r], 4'h2) ^ gmul(a[(r+1)%4], 4'h3) ^
                        a[(r+2)%4] ^ a[(r+3)%4];
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state      <= IDLE;
            blk        <= '0;
            acc        <= '0;
            step       <= '0;
            inv_q      <= 1'b0;
            byp_q      <= 1'b0;
            result_out <= '0;
            out_valid  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        blk   <= block_in;
                        inv_q <= inv_in;
                        byp_q <= byp_sample;
                        acc   <= '0;
                        step  <= '0;
                        state <= MIX;
                    end
                end
                MIX: begin
                    acc <= acc_nxt;
                    if (step == LAST) begin
                        result_out <= byp_q ? blk : acc_nxt;
                        out_valid  <= 1'b1;
                        step       <= '0;
                        state      <= DONE;
                    end else begin
                        step <= step + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready = (state == IDLE);
    assign busy_out = (state != IDLE);

endmodule

// File: tb/tb_mix_cols_pipe.sv
// Bench for mix_cols_pipe: CPC=1/2/4 instances against a GF(2^8) reference model.
module tb_mix_cols_pipe;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [2:0]   in_valid = '0;
    logic [2:0]   in_ready;
    logic [2:0]   inv_in = '0;
    logic [2:0]   out_valid;
    logic [2:0]   out_ready = '0;
    logic [2:0]   busy;
    logic [2:0]   byp = '0;
    logic [127:0] block_in [3];
    logic [127:0] result [3];
    int           errors = 0;
    int           checks = 0;

`ifdef MIX_COLS_BYPASS_EN
    localparam bit HAS_BYP = 1'b1;
`else
    localparam bit HAS_BYP = 1'b0;
`endif

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int CPC = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
        mix_cols_pipe #(.COLS_PER_CYCLE(CPC)) u_dut (
            .clk_in    (clk),
            .rst_n_in  (rst_n),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .inv_in    (inv_in[g]),
            .block_in  (block_in[g]),
            .result_out(result[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .busy_out  (busy[g])
`ifdef MIX_COLS_BYPASS_EN
            ,
            .bypass_in (byp[g])
`endif
        );
    end

    // Carry-less multiply then polynomial reduction by 0x11b.
    function automatic logic [7:0] gm(input logic [7:0] x, input logic [7:0] y);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++)
            if (y[i]) p = p ^ (16'(x) << i);
        for (int i = 14; i >= 8; i--)
            if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [127:0] ref_block(input logic [127:0] b, input bit inv, input bit bp);
        logic [7:0]   coef [4];
        logic [7:0]   o;
        logic [127:0] r;
        if (bp) return b;
        if (inv) begin
            coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
        end else begin
            coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
        end
        r = '0;
        for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++) begin
                o = '0;
                for (int t = 0; t < 4; t++)
                    o = o ^ gm(b[8*(4*((row+t)%4)+c) +: 8], coef[t]);
                r[8*(4*row+c) +: 8] = o;
            end
        return r;
    endfunction

    function automatic logic [127:0] make_block(input logic [31:0] c0, c1, c2, c3);
        logic [31:0]  w [4];
        logic [127:0] b;
        w[0] = c0; w[1] = c1; w[2] = c2; w[3] = c3;
        b = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                b[8*(4*r+c) +: 8] = w[c][31-8*r -: 8];
        return b;
    endfunction

    function automatic int steps(input int k);
        return 4 >> k;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: 0 idle, 1 mixing, 2 result waiting; result due steps(k) edges after accept.
    int           mstate [3];
    int           mcnt [3];
    logic [127:0] mexp [3];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                mstate[k] <= 0;
                mcnt[k]   <= 0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (mstate[k] == 0) begin
                    if (in_valid[k]) begin
                        mexp[k]   <= ref_block(block_in[k], inv_in[k], byp[k]);
                        mcnt[k]   <= 0;
                        mstate[k] <= 1;
                    end
                end else if (mstate[k] == 1) begin
                    mcnt[k] <= mcnt[k] + 1;
                    if (mcnt[k] + 1 == steps(k)) mstate[k] <= 2;
                end else if (out_ready[k]) begin
                    mstate[k] <= 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 3; k++) begin
                check($sformatf("flags%0d", k), {125'd0, in_ready[k], out_valid[k], busy[k]},
                      {125'd0, mstate[k] == 0, mstate[k] == 2, mstate[k] != 0});
                if (mstate[k] == 2)
                    check($sformatf("result%0d", k), result[k], mexp[k]);
            end
        end
    end

    task automatic run_block(input int k, input logic [127:0] blk, input bit inv, input bit bp,
                             input int hold, output logic [127:0] got, output int lat);
        @(negedge clk);
        block_in[k] = blk;
        inv_in[k]   = inv;
        byp[k]      = bp;
        in_valid[k] = 1'b1;
        @(posedge clk);
        #1;
        in_valid[k] = 1'b0;
        block_in[k] = ~blk;
        inv_in[k]   = ~inv;
        lat = 0;
        while (!out_valid[k] && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        got = result[k];
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            check("bp_hold", result[k], got);
            check("bp_flags", {125'd0, in_ready[k], out_valid[k], busy[k]}, 128'd3);
            if (h == 3) begin
                in_valid[k] = 1'b1;
                block_in[k] = {$urandom, $urandom, $urandom, $urandom};
            end
            if (h == 4) in_valid[k] = 1'b0;
        end
        @(negedge clk);
        out_ready[k] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[k] = 1'b0;
        check("drained", {127'd0, out_valid[k]}, 128'd0);
    endtask

    logic [127:0] fwd, fexp, got, back, bv, bvm;
    int           lat;

    initial begin
        for (int k = 0; k < 3; k++) block_in[k] = '0;
        fwd  = make_block(32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hc6c6c6c6);
        fexp = make_block(32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6);
        bv   = make_block(32'hd4d4d4d5, 32'hd4d4d4d5, 32'hd4d4d4d5, 32'hd4d4d4d5);
        bvm  = make_block(32'hd5d5d7d6, 32'hd5d5d7d6, 32'hd5d5d7d6, 32'hd5d5d7d6);

        #1 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            check("reset_flags", {125'd0, in_ready[k], out_valid[k], busy[k]}, 128'd4);
            check("reset_result", result[k], 128'd0);
        end
        @(negedge clk);
        #2 rst_n = 1'b1;

        check("model_fwd", ref_block(fwd, 1'b0, 1'b0), fexp);
        check("model_inv", ref_block(fexp, 1'b1, 1'b0), fwd);
        check("model_col", ref_block(bv, 1'b0, 1'b0), bvm);

        for (int k = 0; k < 3; k++) begin
            run_block(k, fwd, 1'b0, 1'b0, 0, got, lat);
            check($sformatf("fwd_vec%0d", k), got, fexp);
            check($sformatf("fwd_lat%0d", k), 128'(lat), 128'(steps(k)));
            run_block(k, got, 1'b1, 1'b0, 0, back, lat);
            check($sformatf("roundtrip%0d", k), back, fwd);
            check($sformatf("inv_lat%0d", k), 128'(lat), 128'(steps(k)));
        end

        run_block(0, fwd, 1'b0, 1'b0, 10, got, lat);
        check("bp_result", got, fexp);

        @(negedge clk);
        block_in[0] = fexp;
        inv_in[0]   = 1'b1;
        in_valid[0] = 1'b1;
        @(posedge clk);
        #1 in_valid[0] = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            check("midrst_flags", {125'd0, in_ready[k], out_valid[k], busy[k]}, 128'd4);
            check("midrst_result", result[k], 128'd0);
        end
        @(negedge clk);
        #2 rst_n = 1'b1;
        run_block(0, fwd, 1'b0, 1'b0, 0, got, lat);
        check("post_rst", got, fexp);

        if (HAS_BYP) begin
            run_block(0, bv, 1'b0, 1'b1, 0, got, lat);
            check("bypass", got, bv);
            check("bypass_lat", 128'(lat), 128'd4);
            run_block(0, bv, 1'b0, 1'b0, 0, got, lat);
            check("no_bypass", got, bvm);
        end

        repeat (800) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                in_valid[k]  = ($urandom % 3) != 0;
                block_in[k]  = {$urandom, $urandom, $urandom, $urandom};
                inv_in[k]    = 1'($urandom);
                out_ready[k] = 1'($urandom);
                byp[k]       = HAS_BYP ? (($urandom % 4) == 0) : 1'b0;
            end
        end
        @(negedge clk);
        in_valid  = '0;
        out_ready = '1;
        repeat (10) @(negedge clk);
        out_ready = '0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
